// File: rtl/rdoq_level_decider.sv
// RDOQ per-coefficient level decision: issues up to three candidates (max, max-1, 0)
// into Dist_Cal, adds lambda*rate to each returned distortion and keeps the cheapest.
module rdoq_level_decider #(
  parameter int LEVEL_WIDTH     = 64,
  parameter int ABS_LEVEL_WIDTH = 32,
  parameter int QBITS_WIDTH     = 6,
  parameter int SCALE_WIDTH     = 32,
  parameter int DIST_WIDTH      = 162,
  parameter int RATE_WIDTH      = 16,
  parameter int LAMBDA_WIDTH    = 32,
  parameter int COST_WIDTH      = DIST_WIDTH + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       coef_valid,
  output logic                       coef_ready,
  input  logic [LEVEL_WIDTH-1:0]     coef_level_double,
  input  logic [ABS_LEVEL_WIDTH-1:0] coef_max_abs,
  input  logic [QBITS_WIDTH-1:0]     coef_q_bits,
  input  logic [SCALE_WIDTH-1:0]     coef_err_scale,
  input  logic [RATE_WIDTH-1:0]      coef_rate_max,
  input  logic [RATE_WIDTH-1:0]      coef_rate_max_m1,
  input  logic [RATE_WIDTH-1:0]      coef_rate_zero,
  input  logic [LAMBDA_WIDTH-1:0]    lambda,
  output logic                       dist_valid_in,
  output logic [LEVEL_WIDTH-1:0]     dist_l_level_double,
  output logic [ABS_LEVEL_WIDTH-1:0] dist_ui_abs_level,
  output logic [QBITS_WIDTH-1:0]     dist_i_q_bits,
  output logic [SCALE_WIDTH-1:0]     dist_error_scale,
  input  logic                       dist_valid_out,
  input  logic [DIST_WIDTH-1:0]      dist_distortion,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [ABS_LEVEL_WIDTH-1:0] res_abs_level,
  output logic [COST_WIDTH-1:0]      res_cost,
  output logic                       err_unexpected
);
  localparam int PROD_WIDTH = LAMBDA_WIDTH + RATE_WIDTH;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;
  state_t st, nst;

  logic [1:0]                       n_cnt, iss_idx, rcv_idx, n_new;
  logic [LEVEL_WIDTH-1:0]           lvl_q;
  logic [ABS_LEVEL_WIDTH-1:0]       max_q;
  logic [QBITS_WIDTH-1:0]           qb_q;
  logic [SCALE_WIDTH-1:0]           scale_q;
  logic [LAMBDA_WIDTH-1:0]          lam_q;
  logic [2:0][RATE_WIDTH-1:0]       rate_q;   // [0]=max, [1]=max-1, [2]=zero
  logic [2:0][PROD_WIDTH-1:0]       prod_q;   // lambda*rate per issue slot
  logic [2:0][ABS_LEVEL_WIDTH-1:0]  cand_q;   // level per issue slot
  logic                             ready_q;

  logic                       accept, rcv_fire, last_issue, last_rcv;
  logic [ABS_LEVEL_WIDTH-1:0] cand;
  logic [RATE_WIDTH-1:0]      rate_sel;
  logic [COST_WIDTH-1:0]      cost;

  assign accept     = coef_valid && ready_q;
  assign rcv_fire   = (st == WAIT) && dist_valid_out;
  assign last_issue = (iss_idx == n_cnt - 2'd1);
  assign last_rcv   = (rcv_idx == n_cnt - 2'd1);
  assign n_new      = (coef_max_abs == '0) ? 2'd1 :
                      (coef_max_abs == ABS_LEVEL_WIDTH'(1)) ? 2'd2 : 2'd3;

  // The last issue is always level 0; earlier ones count down from max.
  always_comb begin
    cand     = '0;
    rate_sel = rate_q[2];
    if (!last_issue) begin
      cand     = max_q - ABS_LEVEL_WIDTH'(iss_idx);
      rate_sel = (iss_idx == 2'd0) ? rate_q[0] : rate_q[1];
    end
  end

  assign cost = COST_WIDTH'(dist_distortion) + COST_WIDTH'(prod_q[rcv_idx]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= nst;
  end

  always_comb begin
    nst = st;
    case (st)
      IDLE:    if (accept) nst = ISSUE;
      ISSUE:   if (last_issue) nst = WAIT;
      WAIT:    if (rcv_fire && last_rcv) nst = OUT;
      OUT:     if (res_ready) nst = IDLE;
      default: nst = IDLE;
    endcase
  end

  always_comb begin
    coef_ready = ready_q;
    res_valid  = (st == OUT);
  end

  // ready is registered so it stays low throughout reset and rises on the first edge after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q             <= 1'b0;
      n_cnt               <= '0;
      iss_idx             <= '0;
      rcv_idx             <= '0;
      lvl_q               <= '0;
      max_q               <= '0;
      qb_q                <= '0;
      scale_q             <= '0;
      lam_q               <= '0;
      rate_q              <= '0;
      prod_q              <= '0;
      cand_q              <= '0;
      dist_valid_in       <= 1'b0;
      dist_l_level_double <= '0;
      dist_ui_abs_level   <= '0;
      dist_i_q_bits       <= '0;
      dist_error_scale    <= '0;
      res_abs_level       <= '0;
      res_cost            <= '0;
      err_unexpected      <= 1'b0;
    end else begin
      ready_q       <= (nst == IDLE);
      dist_valid_in <= (st == ISSUE);
      if (accept) begin
        lvl_q   <= coef_level_double;
        max_q   <= coef_max_abs;
        qb_q    <= coef_q_bits;
        scale_q <= coef_err_scale;
        lam_q   <= lambda;
        rate_q  <= {coef_rate_zero, coef_rate_max_m1, coef_rate_max};
        n_cnt   <= n_new;
        iss_idx <= '0;
        rcv_idx <= '0;
      end
      if (st == ISSUE) begin
        dist_l_level_double <= lvl_q;
        dist_ui_abs_level   <= cand;
        dist_i_q_bits       <= qb_q;
        dist_error_scale    <= scale_q;
        prod_q[iss_idx]     <= PROD_WIDTH'(lam_q) * PROD_WIDTH'(rate_sel);
        cand_q[iss_idx]     <= cand;
        iss_idx             <= iss_idx + 2'd1;
      end
      // Strict compare: on a tie the earlier (higher) level wins.
      if (rcv_fire) begin
        if (rcv_idx == 2'd0 || cost < res_cost) begin
          res_cost      <= cost;
          res_abs_level <= cand_q[rcv_idx];
        end
        rcv_idx <= rcv_idx + 2'd1;
      end
      if (dist_valid_out && st != WAIT) err_unexpected <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rdoq_level_decider.sv
// Bench for rdoq_level_decider: a 3-stage Dist_Cal model closes the loop and a
// candidate-cost reference picks the expected level for directed and random requests.
module tb_rdoq_level_decider;
  localparam int LW = 64, AW = 32, QW = 6, SW = 32, DW = 162, RW = 16, MW = 32, CW = DW + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          coef_valid, coef_ready;
  logic [LW-1:0] coef_level_double;
  logic [AW-1:0] coef_max_abs;
  logic [QW-1:0] coef_q_bits;
  logic [SW-1:0] coef_err_scale;
  logic [RW-1:0] coef_rate_max, coef_rate_max_m1, coef_rate_zero;
  logic [MW-1:0] lambda;
  logic          dist_valid_in, dist_valid_out;
  logic [LW-1:0] dist_l_level_double;
  logic [AW-1:0] dist_ui_abs_level;
  logic [QW-1:0] dist_i_q_bits;
  logic [SW-1:0] dist_error_scale;
  logic [DW-1:0] dist_distortion;
  logic          res_valid, res_ready, err_unexpected;
  logic [AW-1:0] res_abs_level;
  logic [CW-1:0] res_cost;
  logic          inj;

  rdoq_level_decider dut (
    .clk(clk), .rst_n(rst_n),
    .coef_valid(coef_valid), .coef_ready(coef_ready),
    .coef_level_double(coef_level_double), .coef_max_abs(coef_max_abs),
    .coef_q_bits(coef_q_bits), .coef_err_scale(coef_err_scale),
    .coef_rate_max(coef_rate_max), .coef_rate_max_m1(coef_rate_max_m1),
    .coef_rate_zero(coef_rate_zero), .lambda(lambda),
    .dist_valid_in(dist_valid_in), .dist_l_level_double(dist_l_level_double),
    .dist_ui_abs_level(dist_ui_abs_level), .dist_i_q_bits(dist_i_q_bits),
    .dist_error_scale(dist_error_scale),
    .dist_valid_out(dist_valid_out), .dist_distortion(dist_distortion),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_abs_level(res_abs_level), .res_cost(res_cost),
    .err_unexpected(err_unexpected)
  );

  int vectors = 0, miscompares = 0, cyc = 0, t_acc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Distortion = (level_double - level<<q)^2 * scale
  function automatic logic [DW-1:0] dcal(input logic [LW-1:0] ld, input logic [AW-1:0] a,
                                         input logic [QW-1:0] q, input logic [SW-1:0] s);
    logic [127:0] rec, d;
    rec = {96'b0, a} << q;
    d   = ({64'b0, ld} >= rec) ? {64'b0, ld} - rec : rec - {64'b0, ld};
    return DW'(d) * DW'(d) * DW'(s);
  endfunction

  logic [2:0]    pv;
  logic [DW-1:0] pd0, pd1, pd2;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pv <= '0; pd0 <= '0; pd1 <= '0; pd2 <= '0;
    end else begin
      pv  <= {pv[1:0], dist_valid_in};
      pd0 <= dcal(dist_l_level_double, dist_ui_abs_level, dist_i_q_bits, dist_error_scale);
      pd1 <= pd0;
      pd2 <= pd1;
    end
  assign dist_valid_out  = pv[2] | inj;
  assign dist_distortion = pd2;

  logic [AW-1:0] issued[$];
  int            acc_q[$];
  logic [AW-1:0] rl_q[$];
  logic [CW-1:0] rc_q[$];
  int            run_len = 0, max_run = 0;
  always @(posedge clk) begin
    if (dist_valid_in) begin
      issued.push_back(dist_ui_abs_level);
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else run_len = 0;
    if (coef_valid && coef_ready) acc_q.push_back(cyc);
    if (res_valid && res_ready) begin rl_q.push_back(res_abs_level); rc_q.push_back(res_cost); end
  end

  logic [AW-1:0] exp_lvl;
  logic [CW-1:0] exp_cost;
  int            exp_n;
  logic [103:0]  exp_iss;

  // Reference: candidate list {max, max-1, 0} collapsed for small max, cost = dist + lambda*rate,
  // first minimum in list order wins.
  task automatic model(input logic [LW-1:0] ld, input logic [AW-1:0] a, input logic [QW-1:0] q,
                       input logic [SW-1:0] s, input logic [MW-1:0] lam,
                       input logic [RW-1:0] rm, input logic [RW-1:0] rm1, input logic [RW-1:0] rz);
    logic [AW-1:0] lv[3];
    logic [RW-1:0] rt[3];
    logic [CW-1:0] c;
    exp_n = (a == '0) ? 1 : (a == 32'd1) ? 2 : 3;
    lv[0] = a; rt[0] = rm; lv[1] = a - 32'd1; rt[1] = rm1; lv[2] = '0; rt[2] = rz;
    if (exp_n == 2) rt[1] = rz;
    if (exp_n == 1) begin lv[0] = '0; rt[0] = rz; end
    exp_iss = '0;
    exp_iss[103:96] = 8'(exp_n);
    for (int i = 0; i < exp_n; i++) begin
      c = CW'(dcal(ld, lv[i], q, s)) + CW'(lam) * CW'(rt[i]);
      exp_iss[i*32 +: 32] = lv[i];
      if (i == 0 || c < exp_cost) begin exp_cost = c; exp_lvl = lv[i]; end
    end
  endtask

  function automatic logic [103:0] iss_pack();
    logic [103:0] p = '0;
    p[103:96] = 8'(issued.size());
    for (int i = 0; i < issued.size() && i < 3; i++) p[i*32 +: 32] = issued[i];
    return p;
  endfunction

  task automatic tick(input int k = 1);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic set_fields(input logic [LW-1:0] ld, input logic [AW-1:0] a, input logic [QW-1:0] q,
                            input logic [SW-1:0] s, input logic [MW-1:0] lam,
                            input logic [RW-1:0] rm, input logic [RW-1:0] rm1, input logic [RW-1:0] rz);
    coef_level_double = ld; coef_max_abs = a; coef_q_bits = q; coef_err_scale = s;
    lambda = lam; coef_rate_max = rm; coef_rate_max_m1 = rm1; coef_rate_zero = rz;
  endtask

  task automatic start(input logic [LW-1:0] ld, input logic [AW-1:0] a, input logic [QW-1:0] q,
                       input logic [SW-1:0] s, input logic [MW-1:0] lam,
                       input logic [RW-1:0] rm, input logic [RW-1:0] rm1, input logic [RW-1:0] rz);
    model(ld, a, q, s, lam, rm, rm1, rz);
    set_fields(ld, a, q, s, lam, rm, rm1, rz);
    coef_valid = 1'b1;
    for (int i = 0; i < 50 && !coef_ready; i++) tick();
    issued.delete();
    tick();
    t_acc = cyc;
    coef_valid = 1'b0;
  endtask

  task automatic wait_res(output bit to, output int lat);
    to = 1'b1; lat = 0;
    for (int i = 0; i < 40; i++) begin
      if (res_valid) begin to = 1'b0; lat = cyc - t_acc; break; end
      tick();
    end
  endtask

  task automatic take_res();
    res_ready = 1'b1; tick(); res_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    vectors++; if ({coef_ready, dist_valid_in, res_valid, err_unexpected} !== 4'b0) begin miscompares++; $display("FAIL reset_ctrl: got %b expected 0000", {coef_ready, dist_valid_in, res_valid, err_unexpected}); end
    vectors++; if ({res_abs_level, res_cost, dist_l_level_double, dist_ui_abs_level, dist_i_q_bits, dist_error_scale} !== '0) begin miscompares++; $display("FAIL reset_data: got level %0d cost %0d, expected all data outputs 0", res_abs_level, res_cost); end
    tick(3);
    vectors++; if (coef_ready !== 1'b0) begin miscompares++; $display("FAIL reset_held_ready: got %b expected 0", coef_ready); end
    rst_n = 1'b1;
    tick(2);
    vectors++; if (coef_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release_ready: got %b expected 1", coef_ready); end
  endtask

  task automatic test_basic();
    bit to; int lat;
    start(64'd40, 32'd3, 6'd4, 32'd1, 32'd1, 16'd10, 16'd6, 16'd1);
    wait_res(to, lat);
    vectors++; if (to || lat != 7) begin miscompares++; $display("FAIL basic_latency: got %0d (timeout %0b) expected 7", lat, to); end
    vectors++; if (res_abs_level !== 32'd2 || res_cost !== CW'(70)) begin miscompares++; $display("FAIL basic_result: got %0d/%0d expected 2/70", res_abs_level, res_cost); end
    vectors++; if (iss_pack() !== exp_iss) begin miscompares++; $display("FAIL basic_issue: got %h expected %h", iss_pack(), exp_iss); end
    take_res();
  endtask

  task automatic test_tie();
    bit to; int lat;
    start(64'd40, 32'd3, 6'd4, 32'd1, 32'd1, 16'd5, 16'd5, 16'd1);
    wait_res(to, lat);
    vectors++; if (to || res_abs_level !== 32'd3 || res_cost !== CW'(69)) begin miscompares++; $display("FAIL tie_result: got %0d/%0d (timeout %0b) expected 3/69", res_abs_level, res_cost, to); end
    take_res();
  endtask

  task automatic test_single();
    bit to; int lat;
    start(64'd5, 32'd0, 6'd0, 32'd2, 32'd4, 16'd999, 16'd777, 16'd3);
    wait_res(to, lat);
    vectors++; if (to || lat != 5) begin miscompares++; $display("FAIL single_latency: got %0d (timeout %0b) expected 5", lat, to); end
    vectors++; if (res_abs_level !== 32'd0 || res_cost !== CW'(62)) begin miscompares++; $display("FAIL single_result: got %0d/%0d expected 0/62", res_abs_level, res_cost); end
    vectors++; if (iss_pack() !== exp_iss) begin miscompares++; $display("FAIL single_issue: got %h expected %h", iss_pack(), exp_iss); end
    take_res();
  endtask

  task automatic test_two_hold();
    bit to; int lat;
    start(64'd3, 32'd1, 6'd1, 32'd1, 32'd0, 16'd7, 16'd8, 16'd9);
    wait_res(to, lat);
    vectors++; if (to || lat != 6) begin miscompares++; $display("FAIL two_latency: got %0d (timeout %0b) expected 6", lat, to); end
    vectors++; if (res_abs_level !== 32'd1 || res_cost !== CW'(1)) begin miscompares++; $display("FAIL two_result: got %0d/%0d expected 1/1", res_abs_level, res_cost); end
    vectors++; if (iss_pack() !== exp_iss) begin miscompares++; $display("FAIL two_issue: got %h expected %h", iss_pack(), exp_iss); end
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++; if (res_valid !== 1'b1 || coef_ready !== 1'b0 || dist_valid_in !== 1'b0 || res_abs_level !== 32'd1 || res_cost !== CW'(1)) begin miscompares++; $display("FAIL hold_stable: cycle %0d got v%b r%b d%b %0d/%0d expected v1 r0 d0 1/1", i, res_valid, coef_ready, dist_valid_in, res_abs_level, res_cost); end
    end
    take_res();
    vectors++; if (coef_ready !== 1'b1 || res_valid !== 1'b0) begin miscompares++; $display("FAIL hold_release: got ready %b valid %b expected 1 0", coef_ready, res_valid); end
  endtask

  task automatic test_unexpected();
    bit to; int lat;
    inj = 1'b1; tick(); inj = 1'b0;
    vectors++; if (err_unexpected !== 1'b1) begin miscompares++; $display("FAIL unexp_set: got %b expected 1", err_unexpected); end
    tick(3);
    start(64'd100, 32'd7, 6'd3, 32'd5, 32'd3, 16'd20, 16'd40, 16'd2);
    wait_res(to, lat);
    vectors++; if (to || res_abs_level !== exp_lvl || res_cost !== exp_cost) begin miscompares++; $display("FAIL unexp_next: got %0d/%0d expected %0d/%0d", res_abs_level, res_cost, exp_lvl, exp_cost); end
    vectors++; if (err_unexpected !== 1'b1) begin miscompares++; $display("FAIL unexp_sticky: got %b expected 1", err_unexpected); end
    take_res();
  endtask

  task automatic test_reset_mid();
    bit to; int lat;
    start(64'd40, 32'd3, 6'd4, 32'd1, 32'd1, 16'd10, 16'd6, 16'd1);
    tick(5);
    rst_n = 1'b0; #1;
    vectors++; if ({coef_ready, dist_valid_in, res_valid, err_unexpected} !== 4'b0) begin miscompares++; $display("FAIL midrst_ctrl: got %b expected 0000", {coef_ready, dist_valid_in, res_valid, err_unexpected}); end
    vectors++; if ({res_abs_level, res_cost, dist_l_level_double, dist_ui_abs_level, dist_i_q_bits, dist_error_scale} !== '0) begin miscompares++; $display("FAIL midrst_data: got level %0d cost %0d, expected all data outputs 0", res_abs_level, res_cost); end
    tick(2);
    rst_n = 1'b1;
    issued.delete();
    tick(8);
    vectors++; if (coef_ready !== 1'b1 || res_valid !== 1'b0 || issued.size() != 0) begin miscompares++; $display("FAIL midrst_stale: got ready %b valid %b issues %0d expected 1 0 0", coef_ready, res_valid, issued.size()); end
    start(64'd40, 32'd3, 6'd4, 32'd1, 32'd1, 16'd10, 16'd6, 16'd1);
    wait_res(to, lat);
    vectors++; if (to || lat != 7 || res_abs_level !== 32'd2 || res_cost !== CW'(70)) begin miscompares++; $display("FAIL midrst_next: got %0d/%0d lat %0d expected 2/70 lat 7", res_abs_level, res_cost, lat); end
    take_res();
  endtask

  task automatic test_wide();
    bit to; int lat;
    start(64'hFFFF_FFFF_FFFF_FFFF, 32'd2, 6'd62, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'hFFFF, 16'hFFFE, 16'hFFFF);
    wait_res(to, lat);
    vectors++; if (to || res_abs_level !== exp_lvl || res_cost !== exp_cost) begin miscompares++; $display("FAIL wide3_result: got %0d/%h expected %0d/%h", res_abs_level, res_cost, exp_lvl, exp_cost); end
    take_res();
    start(64'hFFFF_FFFF_FFFF_FFFF, 32'd0, 6'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'd0, 16'd0, 16'hFFFF);
    wait_res(to, lat);
    vectors++; if (to || res_abs_level !== exp_lvl || res_cost !== exp_cost) begin miscompares++; $display("FAIL wide1_result: got %0d/%h expected %0d/%h", res_abs_level, res_cost, exp_lvl, exp_cost); end
    take_res();
  endtask

  task automatic test_back_to_back();
    model(64'd40, 32'd3, 6'd4, 32'd1, 32'd1, 16'd10, 16'd6, 16'd1);
    set_fields(64'd40, 32'd3, 6'd4, 32'd1, 32'd1, 16'd10, 16'd6, 16'd1);
    acc_q.delete(); rl_q.delete(); rc_q.delete();
    coef_valid = 1'b1; res_ready = 1'b1;
    tick(30);
    coef_valid = 1'b0;
    tick(15);
    res_ready = 1'b0;
    vectors++; if (acc_q.size() != 4 || rl_q.size() != 4) begin miscompares++; $display("FAIL b2b_count: got %0d accepts %0d results expected 4 4", acc_q.size(), rl_q.size()); end
    for (int i = 1; i < acc_q.size(); i++) begin
      vectors++; if (acc_q[i] - acc_q[i-1] != 9) begin miscompares++; $display("FAIL b2b_spacing: got %0d expected 9", acc_q[i] - acc_q[i-1]); end
    end
    for (int i = 0; i < rl_q.size(); i++) begin
      vectors++; if (rl_q[i] !== exp_lvl || rc_q[i] !== exp_cost) begin miscompares++; $display("FAIL b2b_result: got %0d/%0d expected %0d/%0d", rl_q[i], rc_q[i], exp_lvl, exp_cost); end
    end
  endtask

  task automatic test_random();
    bit to; int lat;
    logic [LW-1:0] ld; logic [AW-1:0] a; logic [QW-1:0] q;
    for (int it = 0; it < 150; it++) begin
      ld = LW'($urandom_range(0, 1 << 20));
      q  = QW'($urandom_range(0, 6));
      case ($urandom_range(0, 3))
        0:       a = '0;
        1:       a = 32'd1;
        2:       a = AW'(ld >> q) + AW'($urandom_range(0, 2));
        default: a = AW'($urandom_range(2, 40));
      endcase
      start(ld, a, q, SW'($urandom_range(1, 1000)), MW'($urandom_range(0, 2000)),
            RW'($urandom), RW'($urandom), RW'($urandom));
      wait_res(to, lat);
      vectors++; if (to || lat != 4 + exp_n) begin miscompares++; $display("FAIL rand_latency: it %0d got %0d expected %0d", it, lat, 4 + exp_n); end
      vectors++; if (res_abs_level !== exp_lvl || res_cost !== exp_cost) begin miscompares++; $display("FAIL rand_result: it %0d got %0d/%0d expected %0d/%0d", it, res_abs_level, res_cost, exp_lvl, exp_cost); end
      vectors++; if (iss_pack() !== exp_iss) begin miscompares++; $display("FAIL rand_issue: it %0d got %h expected %h", it, iss_pack(), exp_iss); end
      tick($urandom_range(0, 3));
      take_res();
      vectors++; if (coef_ready !== 1'b1) begin miscompares++; $display("FAIL rand_ready: it %0d got %b expected 1", it, coef_ready); end
    end
    vectors++; if (max_run > 3) begin miscompares++; $display("FAIL issue_burst: got %0d expected <= 3", max_run); end
    vectors++; if (err_unexpected !== 1'b0) begin miscompares++; $display("FAIL rand_err: got %b expected 0", err_unexpected); end
  endtask

  initial begin
    coef_valid = 1'b0; res_ready = 1'b0; inj = 1'b0;
    set_fields('0, '0, '0, '0, '0, '0, '0, '0);
    test_reset();
    test_basic();
    test_tie();
    test_single();
    test_two_hold();
    test_unexpected();
    test_reset_mid();
    test_wide();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached with %0d vectors applied", vectors);
    $fatal(1, "watchdog expired");
  end
endmodule
